lrsc_reservation_ctrl: RTL and testbench
========================================

Name: lrsc_reservation_ctrl

Overview:
Per-core LR/SC reservation controller in the memory-access unit. Records the reservation granule on a load-reserved (LR) and resolves each store-conditional (SC) to success or fail. Clears the reservation on coherence invalidation, flush, SC or timeout, and holds off matching probes for a short window after an LR. Drives the LR/SC difftest event stream for co-simulation checking.

Parameters:
ADDR_W, 64, physical address width
GRAN_LG2, 6, log2 of reservation granule in bytes; compare uses addr[ADDR_W-1:GRAN_LG2]
BLOCK_CYC, 16, cycles after LR during which probes are stalled (>=1)
TIMEOUT_CYC, 1024, cycles in RESV before the reservation self-expires (>=2)
CORE_ID, 0, 8-bit core id reported on the difftest event

Ports:
io_clock  in  1  core clock
io_reset_n  in  1  asynchronous active-low reset
io_lr_valid  in  1  LR executes this cycle
io_lr_addr  in  ADDR_W  LR physical address
io_sc_valid  in  1  SC executes this cycle; always accepted
io_sc_addr  in  ADDR_W  SC physical address
io_sc_resp_valid  out  1  SC result valid, 1 cycle after io_sc_valid
io_sc_resp_success  out  1  1 = SC may write, 0 = SC fails (rd=1)
io_inv_valid  in  1  coherence probe/invalidate request
io_inv_addr  in  ADDR_W  probed address
io_inv_ready  out  1  probe accepted this cycle
io_flush  in  1  pipeline flush, exception or xret; kills reservation
io_rsv_valid  out  1  reservation held (state != IDLE)
io_rsv_addr  out  ADDR_W  reserved granule base, low GRAN_LG2 bits zero
io_diff_valid  out  1  difftest LR/SC event valid
io_diff_success  out  1  difftest SC outcome
io_diff_coreid  out  8  difftest core id

Behaviour:
- Reset (async, io_reset_n=0): state=IDLE, blk_cnt=0, age_cnt=0, rsv granule=0, io_sc_resp_valid=0, io_sc_resp_success=0, io_diff_*=0. Reset releases synchronously to io_clock. Reset mid-reservation drops it with no SC response.
- States:
  - IDLE: no reservation.
  - BLOCK: reserved; probes stalled.
  - RESV: reserved; probes accepted.
- match(a) = (a[ADDR_W-1:GRAN_LG2] == rsv granule).
- Per-cycle priority: flush > SC > LR > invalidate > BLOCK/timeout counting.
- flush: next state=IDLE. An SC in the same cycle is dropped and produces no response. An LR in the same cycle is ignored.
- SC (io_sc_valid, no flush):
  - Next cycle: io_sc_resp_valid=1, io_sc_resp_success = (state!=IDLE) && match(io_sc_addr), evaluated on the current-cycle state.
  - Next state=IDLE regardless of outcome.
  - LR in the same cycle is ignored (illegal stimulus; bench flags it).
- LR (no flush, no SC): granule<=io_lr_addr granule, state<=BLOCK, blk_cnt<=BLOCK_CYC-1, age_cnt<=0. Legal from any state; it re-arms an existing reservation.
- BLOCK: blk_cnt decrements each cycle; when blk_cnt==0, state<=RESV. io_inv_ready=0 only when io_inv_valid && match(io_inv_addr); non-matching probes are accepted.
- RESV: io_inv_ready=1. Accepted matching probe -> IDLE. age_cnt increments; at TIMEOUT_CYC-1 -> IDLE. Counter width clog2(TIMEOUT_CYC), no wrap past the terminal value.
- IDLE: io_inv_ready=1.
- io_inv_ready is combinational from state and address.
- Probe and LR in the same cycle: the probe is checked against the old reservation, then LR wins and the state goes to BLOCK.
- SC and matching probe in the same cycle in RESV: SC succeeds (the SC is ordered first); the reservation clears either way.
- io_rsv_valid and io_rsv_addr are registered views of state and granule.

Optional Feature:
LRSC_DIFFTEST_EN.
- Defined: io_diff_valid = io_sc_resp_valid, io_diff_success = io_sc_resp_success, io_diff_coreid = CORE_ID. Each SC response produces exactly one event, in the same cycle as the response.
- Not defined: io_diff_valid, io_diff_success and io_diff_coreid are tied to 0, and no extra flops are inferred.

Test Plan:
1. LR 0x8000_0040, 20 idle cycles, SC 0x8000_0078 -> one cycle later resp_valid=1, success=1; rsv_valid=0 after.
2. LR 0x8000_0040, SC 0x8000_0080 (different granule) -> success=0, reservation cleared; with LRSC_DIFFTEST_EN, diff_valid=1, diff_success=0, coreid=CORE_ID.
3. LR 0x1000, probe 0x1010 on cycle 2 -> inv_ready=0 for cycles 2..16, accepted at cycle 17 (RESV), rsv_valid=0, then SC 0x1000 -> success=0.
4. LR 0x2000, probe 0x3000 on cycle 1 -> inv_ready=1 immediately, reservation kept; SC 0x2000 -> success=1.
5. LR 0x4000, wait BLOCK_CYC+TIMEOUT_CYC cycles -> rsv_valid drops at expiry; SC 0x4000 -> success=0.
6. LR 0x5000, then flush and SC 0x5000 together -> no resp_valid, rsv_valid=0. Separately, assert io_reset_n low mid-RESV -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/lrsc_reservation_ctrl.sv
// lrsc_reservation_ctrl: per-core LR/SC reservation tracker.
// Records the granule on LR, resolves SC to success/fail one cycle later,
// stalls matching probes for BLOCK_CYC cycles after an LR and self-expires
// the reservation after TIMEOUT_CYC cycles in RESV.
// Optional difftest event output: define LRSC_DIFFTEST_EN.
// Assumes GRAN_LG2 >= 1, BLOCK_CYC >= 1, TIMEOUT_CYC >= 2.
`timescale 1ns/1ps
module lrsc_reservation_ctrl #(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned GRAN_LG2    = 6,
  parameter int unsigned BLOCK_CYC   = 16,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter logic [7:0]  CORE_ID     = 8'd0
) (
  input  logic              io_clock,
  input  logic              io_reset_n,
  input  logic              io_lr_valid,
  input  logic [ADDR_W-1:0] io_lr_addr,
  input  logic              io_sc_valid,
  input  logic [ADDR_W-1:0] io_sc_addr,
  output logic              io_sc_resp_valid,
  output logic              io_sc_resp_success,
  input  logic              io_inv_valid,
  input  logic [ADDR_W-1:0] io_inv_addr,
  output logic              io_inv_ready,
  input  logic              io_flush,
  output logic              io_rsv_valid,
  output logic [ADDR_W-1:0] io_rsv_addr,
  output logic              io_diff_valid,
  output logic              io_diff_success,
  output logic [7:0]        io_diff_coreid
);

  localparam int unsigned GW    = ADDR_W - GRAN_LG2;
  localparam int unsigned BLK_W = (BLOCK_CYC > 1) ? $clog2(BLOCK_CYC) : 1;
  localparam int unsigned AGE_W = $clog2(TIMEOUT_CYC);
  localparam logic [BLK_W-1:0] BlkInit = BLK_W'(BLOCK_CYC - 1);
  localparam logic [AGE_W-1:0] AgeLast = AGE_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StBlock, StResv} state_e;

  state_e           state_q;
  logic [GW-1:0]    granule_q;
  logic [BLK_W-1:0] blk_cnt_q;
  logic [AGE_W-1:0] age_cnt_q;
  logic             sc_resp_valid_q;
  logic             sc_resp_success_q;
  logic             sc_match;
  logic             inv_match;

  // Granule compares and probe acceptance (only a matching probe in BLOCK stalls).
  always_comb begin
    sc_match     = (io_sc_addr[ADDR_W-1:GRAN_LG2] == granule_q);
    inv_match    = (io_inv_addr[ADDR_W-1:GRAN_LG2] == granule_q);
    io_inv_ready = !((state_q == StBlock) && io_inv_valid && inv_match);
  end

  // Reservation FSM; priority flush > SC > LR > probe > counting.
  always_ff @(posedge io_clock or negedge io_reset_n) begin
    if (!io_reset_n) begin
      state_q           <= StIdle;
      granule_q         <= '0;
      blk_cnt_q         <= '0;
      age_cnt_q         <= '0;
      sc_resp_valid_q   <= 1'b0;
      sc_resp_success_q <= 1'b0;
    end else begin
      sc_resp_valid_q   <= 1'b0;
      sc_resp_success_q <= 1'b0;
      if (io_flush) begin
        // Same-cycle SC is dropped without a response; LR is ignored.
        state_q <= StIdle;
      end else if (io_sc_valid) begin
        // SC is ordered ahead of any same-cycle probe, so it sees the old state.
        sc_resp_valid_q   <= 1'b1;
        sc_resp_success_q <= (state_q != StIdle) && sc_match;
        state_q           <= StIdle;
      end else if (io_lr_valid) begin
        granule_q <= io_lr_addr[ADDR_W-1:GRAN_LG2];
        state_q   <= StBlock;
        blk_cnt_q <= BlkInit;
        age_cnt_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: ;
          StBlock: begin
            if (blk_cnt_q == '0) begin
              state_q <= StResv;
            end else begin
              blk_cnt_q <= blk_cnt_q - 1'b1;
            end
          end
          StResv: begin
            if (io_inv_valid && inv_match) begin
              state_q <= StIdle;
            end else if (age_cnt_q == AgeLast) begin
              state_q <= StIdle;
            end else begin
              age_cnt_q <= age_cnt_q + 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign io_sc_resp_valid   = sc_resp_valid_q;
  assign io_sc_resp_success = sc_resp_success_q;
  assign io_rsv_valid       = (state_q != StIdle);
  assign io_rsv_addr        = {granule_q, {GRAN_LG2{1'b0}}};

  // Offset bits inside a granule never take part in any compare.
  logic unused_low_bits;
  assign unused_low_bits = ^{io_lr_addr[GRAN_LG2-1:0], io_sc_addr[GRAN_LG2-1:0],
                             io_inv_addr[GRAN_LG2-1:0]};

`ifdef LRSC_DIFFTEST_EN
  // One difftest event per SC response, aligned with it.
  assign io_diff_valid   = sc_resp_valid_q;
  assign io_diff_success = sc_resp_success_q;
  assign io_diff_coreid  = CORE_ID;
`else
  assign io_diff_valid   = 1'b0;
  assign io_diff_success = 1'b0;
  assign io_diff_coreid  = 8'd0;
  logic [7:0] unused_core_id;
  assign unused_core_id = CORE_ID;
`endif

endmodule

// File: tb/tb_lrsc_reservation_ctrl.sv
// Bench for lrsc_reservation_ctrl: vector table plus hand sequences for the
// probe stall window, timeout expiry and asynchronous reset. SC responses are
// checked through a scoreboard queue holding expected cycle and outcome.
`timescale 1ns/1ps
module tb_lrsc_reservation_ctrl;

  localparam int unsigned ADDR_W      = 64;
  localparam int unsigned GRAN_LG2    = 6;
  localparam int unsigned BLOCK_CYC   = 16;
  localparam int unsigned TIMEOUT_CYC = 1024;
  localparam logic [7:0]  CORE_ID     = 8'h5A;

  logic              io_clock = 1'b0;
  logic              io_reset_n = 1'b0;
  logic              io_lr_valid = 1'b0;
  logic [ADDR_W-1:0] io_lr_addr = '0;
  logic              io_sc_valid = 1'b0;
  logic [ADDR_W-1:0] io_sc_addr = '0;
  logic              io_sc_resp_valid;
  logic              io_sc_resp_success;
  logic              io_inv_valid = 1'b0;
  logic [ADDR_W-1:0] io_inv_addr = '0;
  logic              io_inv_ready;
  logic              io_flush = 1'b0;
  logic              io_rsv_valid;
  logic [ADDR_W-1:0] io_rsv_addr;
  logic              io_diff_valid;
  logic              io_diff_success;
  logic [7:0]        io_diff_coreid;

  lrsc_reservation_ctrl #(
    .ADDR_W     (ADDR_W),
    .GRAN_LG2   (GRAN_LG2),
    .BLOCK_CYC  (BLOCK_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CORE_ID    (CORE_ID)
  ) dut (
    .io_clock          (io_clock),
    .io_reset_n        (io_reset_n),
    .io_lr_valid       (io_lr_valid),
    .io_lr_addr        (io_lr_addr),
    .io_sc_valid       (io_sc_valid),
    .io_sc_addr        (io_sc_addr),
    .io_sc_resp_valid  (io_sc_resp_valid),
    .io_sc_resp_success(io_sc_resp_success),
    .io_inv_valid      (io_inv_valid),
    .io_inv_addr       (io_inv_addr),
    .io_inv_ready      (io_inv_ready),
    .io_flush          (io_flush),
    .io_rsv_valid      (io_rsv_valid),
    .io_rsv_addr       (io_rsv_addr),
    .io_diff_valid     (io_diff_valid),
    .io_diff_success   (io_diff_success),
    .io_diff_coreid    (io_diff_coreid)
  );

  always #5 io_clock = ~io_clock;

  int cyc = 0;
  always @(posedge io_clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int   cyc;
    logic succ;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    string       nm;
    logic        lr;
    logic        sc;
    logic        inv;
    logic        flush;
    logic [63:0] a;
    logic [63:0] ia;
    int          idle;
    logic        exp_ready;
    logic        exp_rsv;
    logic [63:0] exp_addr;
    logic        exp_succ;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic lr, input logic sc, input logic inv,
                              input logic flush, input logic [63:0] a, input logic [63:0] ia,
                              input int idle, input logic er, input logic rsv,
                              input logic [63:0] eaddr, input logic succ);
    vec_t v;
    v.nm = nm; v.lr = lr; v.sc = sc; v.inv = inv; v.flush = flush; v.a = a; v.ia = ia;
    v.idle = idle; v.exp_ready = er; v.exp_rsv = rsv; v.exp_addr = eaddr; v.exp_succ = succ;
    return v;
  endfunction

  // SC responses: every one must have been predicted, in the right cycle.
  always @(negedge io_clock) begin
    if (io_reset_n && io_sc_resp_valid) begin
      if (sb.size() == 0) begin
        chk("sc_resp_unexpected", 64'(io_sc_resp_valid), 64'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("sc_resp_cycle", 64'(cyc), 64'(e.cyc));
        chk("sc_resp_success", 64'(io_sc_resp_success), 64'(e.succ));
`ifdef LRSC_DIFFTEST_EN
        chk("diff_valid", 64'(io_diff_valid), 64'd1);
        chk("diff_success", 64'(io_diff_success), 64'(e.succ));
        chk("diff_coreid", 64'(io_diff_coreid), 64'(CORE_ID));
`else
        chk("diff_valid_off", 64'(io_diff_valid), 64'd0);
        chk("diff_success_off", 64'(io_diff_success), 64'd0);
`endif
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge io_clock);
      #1;
    end
  endtask

  // One cycle of stimulus; inv_ready sampled mid-cycle, rsv state after the edge.
  task automatic step(input vec_t v);
    if (v.lr && v.sc && !v.flush) $display("note: illegal LR+SC stimulus in %s", v.nm);
    io_lr_valid  = v.lr;
    io_lr_addr   = v.a;
    io_sc_valid  = v.sc;
    io_sc_addr   = v.a;
    io_inv_valid = v.inv;
    io_inv_addr  = v.ia;
    io_flush     = v.flush;
    if (v.sc && !v.flush) sb.push_back('{cyc: cyc + 1, succ: v.exp_succ});
    @(negedge io_clock);
    if (v.inv) chk({v.nm, "_inv_ready"}, 64'(io_inv_ready), 64'(v.exp_ready));
    @(posedge io_clock);
    #1;
    io_lr_valid  = 1'b0;
    io_sc_valid  = 1'b0;
    io_inv_valid = 1'b0;
    io_flush     = 1'b0;
    chk({v.nm, "_rsv_valid"}, 64'(io_rsv_valid), 64'(v.exp_rsv));
    if (v.exp_rsv) chk({v.nm, "_rsv_addr"}, io_rsv_addr, v.exp_addr);
    if (v.idle > 0) idle(v.idle);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    //                nm             lr sc iv fl addr          inv addr idle rdy rsv eaddr         succ
    vecs.push_back(mk("t1_lr",        1, 0, 0, 0, 64'h8000_0040, 64'h0,    20, 0, 1, 64'h8000_0040, 0));
    vecs.push_back(mk("t1_sc",        0, 1, 0, 0, 64'h8000_0078, 64'h0,     0, 0, 0, 64'h0,         1));
    vecs.push_back(mk("t2_lr",        1, 0, 0, 0, 64'h8000_0078, 64'h0,     0, 0, 1, 64'h8000_0040, 0));
    vecs.push_back(mk("t2_sc",        0, 1, 0, 0, 64'h8000_0080, 64'h0,     0, 0, 0, 64'h0,         0));
    vecs.push_back(mk("t4_lr",        1, 0, 0, 0, 64'h2000,      64'h0,     0, 0, 1, 64'h2000,      0));
    vecs.push_back(mk("t4_probe",     0, 0, 1, 0, 64'h0,         64'h3000,  0, 1, 1, 64'h2000,      0));
    vecs.push_back(mk("t4_sc",        0, 1, 0, 0, 64'h2000,      64'h0,     0, 0, 0, 64'h0,         1));
    vecs.push_back(mk("idle_sc",      0, 1, 0, 0, 64'h2000,      64'h0,     0, 0, 0, 64'h0,         0));
    vecs.push_back(mk("rearm_lr0",    1, 0, 0, 0, 64'h6000,      64'h0,     0, 0, 1, 64'h6000,      0));
    vecs.push_back(mk("rearm_lr1",    1, 0, 0, 0, 64'h7000,      64'h0,     0, 0, 1, 64'h7000,      0));
    vecs.push_back(mk("rearm_sc",     0, 1, 0, 0, 64'h6000,      64'h0,     0, 0, 0, 64'h0,         0));
    vecs.push_back(mk("lrinv_lr0",    1, 0, 0, 0, 64'h9000,      64'h0,    20, 0, 1, 64'h9000,      0));
    vecs.push_back(mk("lrinv_both",   1, 0, 1, 0, 64'hA000,      64'h9000,  0, 1, 1, 64'hA000,      0));
    vecs.push_back(mk("lrinv_block",  0, 0, 1, 0, 64'h0,         64'hA000,  0, 0, 1, 64'hA000,      0));
    vecs.push_back(mk("lrinv_sc",     0, 1, 0, 0, 64'hA000,      64'h0,     0, 0, 0, 64'h0,         1));
    vecs.push_back(mk("scinv_lr",     1, 0, 0, 0, 64'hB000,      64'h0,    20, 0, 1, 64'hB000,      0));
    vecs.push_back(mk("scinv_both",   0, 1, 1, 0, 64'hB000,      64'hB000,  0, 1, 0, 64'h0,         1));
    vecs.push_back(mk("t6_lr",        1, 0, 0, 0, 64'h5000,      64'h0,     0, 0, 1, 64'h5000,      0));
    vecs.push_back(mk("t6_flush_sc",  0, 1, 0, 1, 64'h5000,      64'h0,     0, 0, 0, 64'h0,         0));
    vecs.push_back(mk("flush_lr",     1, 0, 0, 1, 64'hC000,      64'h0,     0, 0, 0, 64'h0,         0));
    vecs.push_back(mk("flush_lr_sc",  0, 1, 0, 0, 64'hC000,      64'h0,     0, 0, 0, 64'h0,         0));

    // Reset state, held in reset.
    #3;
    chk("rst_rsv_valid", 64'(io_rsv_valid), 64'd0);
    chk("rst_rsv_addr", io_rsv_addr, 64'd0);
    chk("rst_resp_valid", 64'(io_sc_resp_valid), 64'd0);
    chk("rst_resp_success", 64'(io_sc_resp_success), 64'd0);
    chk("rst_diff_valid", 64'(io_diff_valid), 64'd0);
    chk("rst_inv_ready", 64'(io_inv_ready), 64'd1);
    repeat (3) @(negedge io_clock);
    io_reset_n = 1'b1;
    @(posedge io_clock);
    #1;

    foreach (vecs[i]) step(vecs[i]);

    // Matching probe stalled for the whole BLOCK window, taken in RESV.
    step(mk("t3_lr", 1, 0, 0, 0, 64'h1000, 64'h0, 0, 0, 1, 64'h1000, 0));
    idle(1);
    for (int k = 2; k <= 17; k++) begin
      step(mk("t3_probe", 0, 0, 1, 0, 64'h0, 64'h1010, 0, (k == 17), (k != 17), 64'h1000, 0));
    end
    step(mk("t3_sc", 0, 1, 0, 0, 64'h1000, 64'h0, 0, 0, 0, 64'h0, 0));

    // Self-expiry: held through the last RESV cycle, gone one edge later.
    step(mk("t5_lr", 1, 0, 0, 0, 64'h4000, 64'h0, 0, 0, 1, 64'h4000, 0));
    idle(BLOCK_CYC + TIMEOUT_CYC - 1);
    chk("t5_before_expiry", 64'(io_rsv_valid), 64'd1);
    idle(1);
    chk("t5_after_expiry", 64'(io_rsv_valid), 64'd0);
    step(mk("t5_sc", 0, 1, 0, 0, 64'h4000, 64'h0, 0, 0, 0, 64'h0, 0));

    // Asynchronous reset in the middle of RESV.
    step(mk("t6r_lr", 1, 0, 0, 0, 64'hD000, 64'h0, 20, 0, 1, 64'hD000, 0));
    #2;
    io_reset_n = 1'b0;
    #1;
    chk("t6r_rsv_valid", 64'(io_rsv_valid), 64'd0);
    chk("t6r_rsv_addr", io_rsv_addr, 64'd0);
    chk("t6r_resp_valid", 64'(io_sc_resp_valid), 64'd0);
    chk("t6r_resp_success", 64'(io_sc_resp_success), 64'd0);
    chk("t6r_diff_valid", 64'(io_diff_valid), 64'd0);
    chk("t6r_diff_success", 64'(io_diff_success), 64'd0);
    @(negedge io_clock);
    @(negedge io_clock);
    io_reset_n = 1'b1;
    @(posedge io_clock);
    #1;
    step(mk("t6r_sc", 0, 1, 0, 0, 64'hD000, 64'h0, 0, 0, 0, 64'h0, 0));

    idle(3);
    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
